// File: rtl/deadcode_pipe.sv
// deadcode_pipe -- multi-channel delay-and-reduce pipeline with a valid/ready
// output handshake.
//
// CHANNELS samples of WIDTH bits travel through DEPTH pipeline stages. The
// last stage is reduced to one word, either the sum (MODE 0) or the unsigned
// maximum (MODE 1) of the channels. The result is registered into
// out_data/out_valid.
//
// The block also carries logic that no output observes: per-stage tap copies,
// a shadow transfer counter and a constant-zero output offset. A dead-code
// pass is expected to remove that logic without changing any output waveform.
//
// Optional feature macro: DEADCODE_PIPE_DEBUG_EN
//   defined   -> the last tap register is printed whenever it changes
//                (simulation only).
//   undefined -> the taps have no reader.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input word present
//   in_ready   input accepted when in_valid && in_ready (combinational)
//   in_data    channel k at bits [k*WIDTH +: WIDTH]
//   out_valid  out_data holds a result
//   out_ready  consumer accepts the result
//   out_data   reduced result, zero-extended to OUT_WIDTH
//   out_count  number of completed output transfers, wraps at 16 bits

module deadcode_pipe #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 4,
  parameter int OUT_WIDTH = 32,
  parameter int MODE      = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [15:0]               out_count
);

  localparam int DW    = CHANNELS * WIDTH;
  localparam int OFF_W = $clog2(OUT_WIDTH);

  logic                 adv_s;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DW-1:0]        data_q [DEPTH];
  logic [DW-1:0]        data_d [DEPTH];
  logic [DW-1:0]        tap_q  [DEPTH];
  logic [DW-1:0]        tap_d  [DEPTH];
  logic [OUT_WIDTH-1:0] red_s;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]          count_q, count_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [OFF_W-1:0]     slice_off_s;
  logic                 unused_dead_s;

  // A global stall freezes every stage; it is released when the output slot is empty or being drained.
  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = adv_s;

  // The offset vector is tied to zero, so the shift always selects bit 0 and out_data is unchanged.
  assign slice_off_s = {OFF_W{1'b0}};
  assign out_data    = out_data_q >> slice_off_s;
  assign out_valid   = out_valid_q;
  assign out_count   = count_q;

  // Next state of the stage shift register and the tap copies.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      tap_d[i]  = tap_q[i];
    end
    if (adv_s) begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        tap_d[i] = data_q[i];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Reducer over the last stage: a full-precision sum or an unsigned maximum.
  always_comb begin
    red_s = {OUT_WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (MODE == 1) begin
        if (OUT_WIDTH'(data_q[DEPTH-1][k*WIDTH +: WIDTH]) > red_s) begin
          red_s = OUT_WIDTH'(data_q[DEPTH-1][k*WIDTH +: WIDTH]);
        end else begin
          red_s = red_s;
        end
      end else begin
        red_s = red_s + OUT_WIDTH'(data_q[DEPTH-1][k*WIDTH +: WIDTH]);
      end
    end
  end

  // Next state of the output register and the transfer counters.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    if (adv_s) begin
      out_valid_d = valid_q[DEPTH-1];
      if (valid_q[DEPTH-1]) begin
        out_data_d = red_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (out_valid_q && out_ready) begin
      count_d  = count_q + 16'd1;
      shadow_d = shadow_q + 16'd1;
    end else begin
      count_d  = count_q;
      shadow_d = shadow_q;
    end
  end

  // State registers; reset takes priority over every advance and handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= {DEPTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_WIDTH{1'b0}};
      count_q     <= 16'd0;
      shadow_q    <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DW{1'b0}};
        tap_q[i]  <= {DW{1'b0}};
      end
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        tap_q[i]  <= tap_d[i];
      end
    end
  end

  // Collapse the unobserved taps and shadow counter into one sink bit that drives nothing.
  always_comb begin
    unused_dead_s = ^shadow_q;
    for (int i = 0; i < DEPTH; i++) begin
      unused_dead_s = unused_dead_s ^ (^tap_q[i]);
    end
  end

`ifdef DEADCODE_PIPE_DEBUG_EN
  // Debug trace of the last tap register whenever its value changes.
  always @(*) begin
    $display("tap%0d = %h", DEPTH - 1, tap_q[DEPTH-1]);
  end
`endif

endmodule

// File: tb/tb_deadcode_pipe.sv
module tb_deadcode_pipe;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int DP = 4;
  localparam int OW = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [CH*W-1:0] in_data = 16'h0000;

  logic           in_ready_s, in_ready_m;
  logic           out_valid_s, out_valid_m;
  logic [OW-1:0]  out_data_s, out_data_m;
  logic [15:0]    out_count_s, out_count_m;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_sum_q[$];
  logic [31:0] exp_max_q[$];
  int          exp_count = 0;
  logic        have_prev = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_ds, prev_dm;

  always #5 clock = ~clock;

  deadcode_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP), .OUT_WIDTH(OW), .MODE(0)) dut_sum (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_count(out_count_s));

  deadcode_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP), .OUT_WIDTH(OW), .MODE(1)) dut_max (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_data(out_data_m), .out_count(out_count_m));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on the channel values themselves.
  function automatic logic [31:0] ref_sum(input logic [15:0] d);
    int s;
    s = int'(d[7:0]) + int'(d[15:8]);
    return 32'(s);
  endfunction

  function automatic logic [31:0] ref_max(input logic [15:0] d);
    int a, b;
    a = int'(d[7:0]);
    b = int'(d[15:8]);
    return (a > b) ? 32'(a) : 32'(b);
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clock) begin
    if (reset) begin
      exp_sum_q.delete();
      exp_max_q.delete();
      exp_count = 0;
      have_prev = 1'b0;
    end else begin
      check("out_count_sum", {16'h0, out_count_s}, {16'h0, 16'(exp_count)});
      check("out_count_max", {16'h0, out_count_m}, {16'h0, 16'(exp_count)});
      check("in_ready", {31'h0, in_ready_s}, {31'h0, (!out_valid_s || out_ready)});
      check("valid_match", {31'h0, out_valid_m}, {31'h0, out_valid_s});
      if (have_prev && prev_stall) begin
        check("stall_valid", {31'h0, out_valid_s}, 32'h1);
        check("stall_data_sum", out_data_s, prev_ds);
        check("stall_data_max", out_data_m, prev_dm);
        check("stall_in_ready", {31'h0, in_ready_s}, {31'h0, out_ready});
      end
      if (in_valid && in_ready_s) begin
        exp_sum_q.push_back(ref_sum(in_data));
        exp_max_q.push_back(ref_max(in_data));
      end
      if (out_valid_s && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL stale_output: got %h with no word pending", out_data_s);
        end else begin
          check("data_sum", out_data_s, exp_sum_q.pop_front());
          check("data_max", out_data_m, exp_max_q.pop_front());
        end
        exp_count++;
      end
      prev_stall = out_valid_s && !out_ready;
      prev_ds    = out_data_s;
      prev_dm    = out_data_m;
      have_prev  = 1'b1;
    end
  end

  task automatic send(input logic [15:0] d);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    forever begin
      @(negedge clock);
      if (in_ready_s) break;
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: in_ready stuck at %b", in_ready_s);
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_sum_q.size() == 0) break;
      @(posedge clock);
      #1;
    end
    check("drain_empty", 32'(exp_sum_q.size()), 32'h0);
  endtask

  initial begin
    // Reset held for two cycles, then idle.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_out_valid", {31'h0, out_valid_s}, 32'h0);
      check("rst_out_data", out_data_s, 32'h0);
      check("rst_out_count", {16'h0, out_count_s}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready_s}, 32'h1);
      @(posedge clock);
      #1;
    end

    // Latency: accepted at edge 0, visible after edge DP.
    in_valid = 1'b1;
    in_data  = {8'h20, 8'h10};
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int e = 0; e <= DP; e++) begin
      if (e < DP) begin
        check("latency_early", {31'h0, out_valid_s}, 32'h0);
        @(posedge clock);
        #1;
      end else begin
        check("latency_valid", {31'h0, out_valid_s}, 32'h1);
        check("latency_data", out_data_s, 32'h30);
      end
    end
    @(posedge clock);
    #1;
    check("first_count", {16'h0, out_count_s}, 32'h1);

    // Boundary values: carry kept in the sum, max ignores the smaller channel.
    send({8'hFF, 8'hFF});
    send({8'h80, 8'h05});
    send({8'h05, 8'h80});
    send({8'h00, 8'h00});
    drain();

    // Stream with a 3-cycle consumer stall in the middle.
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          logic [7:0] v;
          v = 8'(i);
          send({v, v});
        end
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(2) != 0);
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three words in flight.
    send(16'h0102);
    send(16'h0304);
    send(16'h0506);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("flush_out_valid", {31'h0, out_valid_s}, 32'h0);
    check("flush_out_count", {16'h0, out_count_s}, 32'h0);
    repeat (12) @(posedge clock);
    #1;
    check("flush_idle_valid", {31'h0, out_valid_s}, 32'h0);

    // out_count wrap: exactly 65536 transfers after reset.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = 16'($urandom);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("wrap_count_sum", {16'h0, out_count_s}, 32'h0);
    check("wrap_count_max", {16'h0, out_count_m}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
